// File: rtl/multdiv_pkg.sv
// Shared definitions for the sequential multiplier and divider.
// Holds the default operand width, the iteration count the radix-4
// multiplier derives from it, the step counter width and the
// IDLE/RUN/DONE state encoding used by both engines.
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int STEPS_DEF = WIDTH_DEF / 2;
    localparam int CNT_W_DEF = $clog2(STEPS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_adder.sv
// Generic N-bit carry-lookahead adder shared by the arithmetic units.
// Ports:
//   a, b  : N-bit addends
//   cin   : carry into bit 0 (used as the +1 of a two's-complement subtract)
//   sum   : N-bit sum, carry out of the top bit is discarded
module cla_adder #(
    parameter int N = 34
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N-1:0] carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is the generate/propagate recurrence written out per bit;
    // synthesis flattens it into lookahead logic.
    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < N - 1; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign sum = prop ^ carry;

endmodule

// File: rtl/mult_step.sv
// One radix-4 Booth iteration, purely combinational.
// Recodes the triplet {q[1], q[0], q_m1} into 0, +M, +2M, -M or -2M,
// adds it to the accumulator and arithmetic-shifts {acc, q, q_m1} right by 2.
// Ports:
//   acc, q, q_m1                : current partial-product state
//   m                           : signed multiplicand
//   acc_next, q_next, q_m1_next : state after this iteration
module mult_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH+1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH+1:0] acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [2:0]         triplet;
    logic [WIDTH+1:0]   m_one;
    logic [WIDTH+1:0]   m_two;
    logic [WIDTH+1:0]   magnitude;
    logic               negate;
    logic [WIDTH+1:0]   addend;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH+2:0] joined;
    logic [2*WIDTH+2:0] shifted;

    assign triplet = {q[1], q[0], q_m1};
    assign m_one   = {{2{m[WIDTH-1]}}, m};
    assign m_two   = {m[WIDTH-1], m, 1'b0};

    always_comb begin
        magnitude = '0;
        negate    = 1'b0;
        case (triplet)
            3'b001, 3'b010: magnitude = m_one;
            3'b011:         magnitude = m_two;
            3'b100: begin
                magnitude = m_two;
                negate    = 1'b1;
            end
            3'b101, 3'b110: begin
                magnitude = m_one;
                negate    = 1'b1;
            end
            default:        magnitude = '0;
        endcase
    end

    // Subtraction is invert-plus-carry-in; the two guard bits keep -2M
    // representable even for the most negative multiplicand.
    assign addend = negate ? ~magnitude : magnitude;

    cla_adder #(
        .N(WIDTH + 2)
    ) u_add (
        .a  (acc),
        .b  (addend),
        .cin(negate),
        .sum(sum)
    );

    assign joined  = {sum, q, q_m1};
    assign shifted = {{2{sum[WIDTH+1]}}, joined[2*WIDTH+2:2]};

    assign acc_next  = shifted[2*WIDTH+2:WIDTH+1];
    assign q_next    = shifted[WIDTH:1];
    assign q_m1_next = shifted[0];

endmodule

// File: rtl/mult_booth4.sv
// Sequential signed multiplier, radix-4 Booth, one recoding step per clock.
// A start strobe latches both operands; WIDTH/2 steps later the low half of
// the product and an overflow flag are presented with a one-cycle ready pulse.
// A new start at any time (including mid-operation) restarts the engine.
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   ctrl_MULT        : start strobe
//   data_operandA/B  : signed multiplicand / multiplier
//   data_result      : low WIDTH bits of the product (held until next start)
//   data_exception   : product does not fit in WIDTH signed bits
//   data_resultRDY   : one-cycle pulse when result/exception are valid
//   busy             : high while steps are being executed
module mult_booth4
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int STEPS = WIDTH / 2;
    localparam int CNT_W = $clog2(STEPS);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH+1:0] acc_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_m1_reg;

    logic [WIDTH+1:0] acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             q_m1_nxt;
    logic             last_step;
    logic             overflow;

    mult_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc      (acc_reg),
        .q        (q_reg),
        .q_m1     (q_m1_reg),
        .m        (m_reg),
        .acc_next (acc_nxt),
        .q_next   (q_nxt),
        .q_m1_next(q_m1_nxt)
    );

    assign last_step = (cnt == CNT_W'(STEPS - 1));

    // After the final step the product sits in {acc[WIDTH-1:0], q}; it fits
    // only if the upper half is a pure sign extension of q's top bit.
    assign overflow = (acc_nxt[WIDTH-1:0] != {WIDTH{q_nxt[WIDTH-1]}});

    // A start strobe takes priority over whatever the engine is doing, so
    // a held strobe simply restarts every edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            m_reg          <= '0;
            acc_reg        <= '0;
            q_reg          <= '0;
            q_m1_reg       <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT) begin
                state          <= RUN;
                cnt            <= '0;
                m_reg          <= data_operandA;
                q_reg          <= data_operandB;
                acc_reg        <= '0;
                q_m1_reg       <= 1'b0;
                data_result    <= '0;
                data_exception <= 1'b0;
                busy           <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        acc_reg  <= acc_nxt;
                        q_reg    <= q_nxt;
                        q_m1_reg <= q_m1_nxt;
                        if (last_step) begin
                            cnt            <= '0;
                            state          <= DONE;
                            busy           <= 1'b0;
                            data_resultRDY <= 1'b1;
                            data_result    <= q_nxt;
                            data_exception <= overflow;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_booth4.sv
// Self-checking bench for mult_booth4: directed vector table, randomized
// operands against an integer-arithmetic reference, and hand-written
// sequences for abort, held start, back-to-back start and reset.
module tb_mult_booth4;

    localparam int W = 32;
    localparam int LAT = 16;
    localparam int LIMIT = 40;

    logic         clock;
    logic         reset;
    logic         ctrl_MULT;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int n_checks = 0;
    int n_fails  = 0;

    mult_booth4 #(
        .WIDTH(W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_MULT     (ctrl_MULT),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         exc;
    } vec_t;

    vec_t vecs[8];

    // Reference: full-precision signed product, then the low word and a
    // range test against the WIDTH-bit signed limits.
    function automatic logic [W:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        logic   exc;
        p   = longint'($signed(a)) * longint'($signed(b));
        exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        return {exc, p[W-1:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Presents one start strobe; returns at the falling edge after the
    // edge that accepted it.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 1'b0;
    endtask

    // Counts edges after the start edge until ready, bounded by LIMIT.
    task automatic waitResult(output int cycles, output int busy_cycles, output logic seen);
        seen        = 1'b0;
        cycles      = 0;
        busy_cycles = busy ? 1 : 0;
        while (!seen && cycles < LIMIT) begin
            @(negedge clock);
            cycles++;
            if (data_resultRDY) seen = 1'b1;
            else if (busy) busy_cycles++;
        end
    endtask

    task automatic runAndCheck(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] exp_res, input logic exp_exc);
        int   cyc;
        int   bcyc;
        logic seen;
        applyStimulus(a, b);
        checkOutput({name, " cleared on start"}, 64'(data_result), 64'd0);
        waitResult(cyc, bcyc, seen);
        checkOutput({name, " ready seen"}, 64'(seen), 64'd1);
        checkOutput({name, " latency"}, 64'(cyc), 64'(LAT));
        checkOutput({name, " busy cycles"}, 64'(bcyc), 64'(LAT));
        checkOutput({name, " result"}, 64'(data_result), 64'(exp_res));
        checkOutput({name, " exception"}, 64'(data_exception), 64'(exp_exc));
        @(negedge clock);
        checkOutput({name, " ready single pulse"}, 64'(data_resultRDY), 64'd0);
        checkOutput({name, " result held"}, 64'(data_result), 64'(exp_res));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           cyc;
        int           bcyc;
        int           rdy_count;
        logic         seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W:0]   expv;

        vecs[0] = '{"3x4",          32'd3,          32'd4,          32'h0000000C, 1'b0};
        vecs[1] = '{"-7x6",         32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0};
        vecs[2] = '{"minx-1",       32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1};
        vecs[3] = '{"minx1",        32'h80000000,   32'd1,          32'h80000000, 1'b0};
        vecs[4] = '{"2^16x2^16",    32'h00010000,   32'h00010000,   32'h00000000, 1'b1};
        vecs[5] = '{"maxxmax",      32'h7FFFFFFF,   32'h7FFFFFFF,   32'h00000001, 1'b1};
        vecs[6] = '{"0xk",          32'd0,          32'h12345678,   32'h00000000, 1'b0};
        vecs[7] = '{"minxmin",      32'h80000000,   32'h80000000,   32'h00000000, 1'b1};

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clock);
        checkOutput("reset result", 64'(data_result), 64'd0);
        checkOutput("reset exception", 64'(data_exception), 64'd0);
        checkOutput("reset ready", 64'(data_resultRDY), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runAndCheck(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);
        end

        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = W'($urandom_range(0, 200)) - 32'd100; rb = W'($urandom_range(0, 200)) - 32'd100; end
                default: begin ra = $urandom >> $urandom_range(0, 31); rb = $urandom >> $urandom_range(0, 31); end
            endcase
            expv = refModel(ra, rb);
            runAndCheck($sformatf("rand%0d", i), ra, rb, expv[W-1:0], expv[W]);
        end

        // Abort mid-run: only the second operation may report.
        applyStimulus(32'd2, 32'd3);
        rdy_count = 0;
        repeat (4) begin
            @(negedge clock);
            if (data_resultRDY) rdy_count++;
        end
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF);
        waitResult(cyc, bcyc, seen);
        checkOutput("abort no early ready", 64'(rdy_count), 64'd0);
        checkOutput("abort latency", 64'(cyc), 64'(LAT));
        checkOutput("abort result", 64'(data_result), 64'h1);
        checkOutput("abort exception", 64'(data_exception), 64'd0);

        // Held start: the last sampled operands win.
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = 32'd100; data_operandB = 32'd100;
        @(negedge clock);
        data_operandA = 32'd55; data_operandB = 32'd2;
        @(negedge clock);
        data_operandA = 32'd7;  data_operandB = 32'hFFFFFFFD;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        waitResult(cyc, bcyc, seen);
        checkOutput("held latency", 64'(cyc), 64'(LAT));
        checkOutput("held result", 64'(data_result), 64'hFFFFFFEB);

        // Start accepted in the DONE cycle goes straight back to RUN.
        applyStimulus(32'd9, 32'd9);
        waitResult(cyc, bcyc, seen);
        checkOutput("b2b first result", 64'(data_result), 64'd81);
        ctrl_MULT = 1'b1; data_operandA = 32'hFFFFFFFB; data_operandB = 32'd4;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        checkOutput("b2b busy", 64'(busy), 64'd1);
        checkOutput("b2b cleared", 64'(data_result), 64'd0);
        waitResult(cyc, bcyc, seen);
        checkOutput("b2b latency", 64'(cyc), 64'(LAT));
        checkOutput("b2b result", 64'(data_result), 64'hFFFFFFEC);
        repeat (3) @(negedge clock);
        checkOutput("idle hold result", 64'(data_result), 64'hFFFFFFEC);

        // Reset clears held results and wins over a simultaneous start.
        reset = 1'b1; ctrl_MULT = 1'b1;
        @(negedge clock);
        reset = 1'b0; ctrl_MULT = 1'b0;
        checkOutput("reset over start busy", 64'(busy), 64'd0);
        checkOutput("reset clears result", 64'(data_result), 64'd0);

        // Reset in the middle of a run: nothing may be reported afterwards.
        applyStimulus(32'd5, 32'd5);
        repeat (8) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midrun reset result", 64'(data_result), 64'd0);
        checkOutput("midrun reset exception", 64'(data_exception), 64'd0);
        checkOutput("midrun reset ready", 64'(data_resultRDY), 64'd0);
        checkOutput("midrun reset busy", 64'(busy), 64'd0);
        rdy_count = 0;
        repeat (20) begin
            @(negedge clock);
            if (data_resultRDY) rdy_count++;
        end
        checkOutput("midrun reset no ready", 64'(rdy_count), 64'd0);

        // Engine still works after reset.
        runAndCheck("after reset", 32'd5, 32'd5, 32'd25, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mult_booth4.md
MULT_BOOTH4 -- requirements
Module: mult_booth4

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width.
REQ-002 Port: clock  input  1  single system clock, rising-edge active.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: ctrl_MULT  input  1  start strobe, sampled on rising edge.
REQ-005 Port: data_operandA  input  WIDTH  signed multiplicand, sampled with ctrl_MULT.
REQ-006 Port: data_operandB  input  WIDTH  signed multiplier, sampled with ctrl_MULT.
REQ-007 Port: data_result  output  WIDTH  low WIDTH bits of signed product.
REQ-008 Port: data_exception  output  1  signed product does not fit in WIDTH bits.
REQ-009 Port: data_resultRDY  output  1  one-cycle pulse, result and exception valid.
REQ-010 Port: busy  output  1  high while an operation is in progress.

Function
REQ-011 Algorithm SHALL be radix-4 Booth, two's-complement signed; one recoding step per clock; WIDTH/2 = 16 steps.
REQ-012 State machine SHALL have states IDLE, RUN, DONE.
REQ-013 IDLE: ctrl_MULT=1 at an edge -> latch both operands, clear accumulator, step counter=0, enter RUN.
REQ-014 RUN: each edge SHALL examine triplet {Q[1],Q[0],Q[-1]}, add 0, +M, +2M, -M or -2M to a (WIDTH+2)-bit accumulator, arithmetic-shift {acc,Q,Q[-1]} right by 2, increment counter.
REQ-015 RUN -> DONE on the edge completing step 15; counter SHALL wrap to 0 there.
REQ-016 DONE: data_resultRDY=1 for exactly one cycle; next edge -> IDLE (or RUN if ctrl_MULT=1).
REQ-017 Latency: data_resultRDY SHALL be high in the cycle after the 16th rising edge following the edge that sampled ctrl_MULT.
REQ-018 -M and -2M SHALL be formed by one's complement plus carry-in, so M = -2^(WIDTH-1) is handled without special casing.
REQ-019 data_result SHALL equal product[WIDTH-1:0]; data_exception=1 iff product[2*WIDTH-1:WIDTH-1] not all-equal.
REQ-020 data_result and data_exception SHALL hold their values from DONE until the next ctrl_MULT is accepted, then go to 0.
REQ-021 ctrl_MULT=1 during RUN SHALL abort the current operation and restart with newly sampled operands, counter=0; no data_resultRDY for the aborted operation.
REQ-022 busy SHALL be 1 in RUN, 0 in IDLE and DONE.
REQ-023 ctrl_MULT held high for multiple cycles SHALL be treated as repeated starts (restart each edge).

Reset
REQ-024 reset=1 at an edge SHALL force IDLE regardless of state, including mid-RUN; it overrides ctrl_MULT.
REQ-025 Reset values: data_result=0, data_exception=0, data_resultRDY=0, busy=0, counter=0, accumulator/Q registers=0.
REQ-026 An operation interrupted by reset SHALL never produce data_resultRDY.

Structure
REQ-027 Shared package multdiv_pkg SHALL hold WIDTH default, step count (WIDTH/2), counter width, and the IDLE/RUN/DONE state encoding, shared with the divider.
REQ-028 One combinational sub-module mult_step SHALL take current {acc,Q,Q[-1]} and multiplicand, return next-step value (recode, add/sub, shift); reuse existing cla_adder for the add.
REQ-029 FSM, counter, operand latches and output registers SHALL live in mult_booth4.

Verification
REQ-030 A=3, B=4 -> data_result=0x0000000C, exception=0, data_resultRDY single pulse 16 cycles after start edge, busy high 16 cycles.
REQ-031 A=-7 (0xFFFFFFF9), B=6 -> data_result=0xFFFFFFD6, exception=0.
REQ-032 A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, exception=1; A=0x80000000, B=1 -> 0x80000000, exception=0.
REQ-033 A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1.
REQ-034 Start A=5,B=5; reset at step 8 -> all outputs 0 next cycle, no data_resultRDY within 20 cycles.
REQ-035 Start A=2,B=3; re-start at step 5 with A=-1,B=-1 -> single data_resultRDY 16 cycles after the second start, data_result=0x00000001, exception=0.
